decoder_3to8: RTL and testbench
===============================

// Module: decoder_3to8
// PURPOSE
//  3-to-8 one-hot decoder with active-high enable, plus an optional registered copy of the output.
//  Two internal decode paths compute the same function and are cross-checked every cycle:
//    - a gate-level path (AND of true/complemented select bits and en)
//    - a case-statement path
//  Used wherever a 3-bit select must drive eight one-hot strobes. Mismatch flag is a built-in self-check.
// PARAMETERS
//  CHECK_EN   1   1: compare gate-level and case decodes each clock; 0: mismatch tied to 0
//  REG_OUT    1   1: d_q is the registered copy of d; 0: d_q tied to d (no flop stage)
// PORTS
//  clk        in   1  system clock, rising-edge
//  reset      in   1  asynchronous, active-low reset (0 = in reset)
//  en         in   1  decoder enable, active-high
//  in         in   3  select code
//  d          out  8  combinational one-hot decode output (case path)
//  d_q        out  8  d registered on clk (REG_OUT=1)
//  d_q_valid  out  1  1 once d_q holds a decode sampled after reset release
//  mismatch   out  1  sticky: gate-level and case decodes disagreed
// BEHAVIOUR
//  - Function of d (purely combinational, zero latency, independent of clk/reset):
//      en=0            -> d = 8'b0000_0000 for every in
//      en=1            -> d = 8'b1 << in; exactly one bit high, bit index = in
//      e.g. in=3'b000 -> 8'b0000_0001; in=3'b101 -> 8'b0010_0000; in=3'b111 -> 8'b1000_0000
//  - d is never all-ones and never has more than one bit set.
//  - If en or in is X/Z, the case path drives d = 8'h00 (default branch).
//  - Gate-level path: g[k] = en & (in[2]~^k[2]) & (in[1]~^k[1]) & (in[0]~^k[0]) for k = 0..7.
//    It must be written as explicit gates, not shifts or case statements.
//  - reset=0 (asynchronous, immediate): d_q = 8'h00, d_q_valid = 0, mismatch = 0.
//  - Each rising clk edge while reset=1:
//      d_q <= d; d_q_valid <= 1
//      if CHECK_EN and g != d then mismatch <= 1
//  - mismatch holds at 1 until the next reset assertion.
//  - Output latency:
//      d      : 0 cycles
//      d_q    : 1 cycle (value of d just before the edge)
//  - Reset asserted mid-operation clears d_q, d_q_valid and mismatch at once; d keeps following en/in.
//  - First edge after reset release loads d_q and sets d_q_valid.
//  - REG_OUT=0: d_q = d combinationally and d_q_valid = reset.
// TESTING
//  1. Hold reset=0, en=1, in=3'b010 -> d=8'h04; d_q=8'h00, d_q_valid=0, mismatch=0 throughout.
//  2. Release reset, en=0, sweep in 0..7 one per clk -> d=8'h00 every cycle; d_q=8'h00.
//  3. en=1, sweep in 0..7 -> d = 01,02,04,08,10,20,40,80 (hex); d_q lags by one clk; mismatch=0.
//  4. Toggle en 1->0 with in=3'b111 held -> d goes 8'h80 to 8'h00 with no clk edge; d_q follows next edge.
//  5. Assert reset mid-sweep with d_q=8'h10 -> d_q=8'h00, d_q_valid=0 before the next clk edge.
//  6. Force internal g[0] stuck-at-1 with en=1, in=3'b001 -> mismatch=1 after that edge; stays 1 until reset.

Source files
------------

// File: rtl/decoder_3to8.sv
// decoder_3to8: one-hot 3-to-8 decoder with a gate-level/case cross-check and optional output register
module decoder_3to8 #(
    parameter bit CHECK_EN = 1'b1,
    parameter bit REG_OUT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] d,
    output logic [7:0] d_q,
    output logic       d_q_valid,
    output logic       mismatch
);
    logic [7:0] g;

    for (genvar k = 0; k < 8; k++) begin : g_gate
        localparam logic [2:0] sel_k = 3'(k);
        assign g[k] = en & (in[2] ~^ sel_k[2]) & (in[1] ~^ sel_k[1]) & (in[0] ~^ sel_k[0]);
    end

    // Unknown en/in falls to the default branch and yields all zeros
    always_comb begin
        case ({en, in})
            4'b1000: d = 8'h01;
            4'b1001: d = 8'h02;
            4'b1010: d = 8'h04;
            4'b1011: d = 8'h08;
            4'b1100: d = 8'h10;
            4'b1101: d = 8'h20;
            4'b1110: d = 8'h40;
            4'b1111: d = 8'h80;
            default: d = 8'h00;
        endcase
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                d_q       <= 8'h00;
                d_q_valid <= 1'b0;
            end else begin
                d_q       <= d;
                d_q_valid <= 1'b1;
            end
        end
    end else begin : g_noreg
        assign d_q       = d;
        assign d_q_valid = reset;
    end

    if (CHECK_EN) begin : g_chk
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                mismatch <= 1'b0;
            else if (g != d)
                mismatch <= 1'b1;
        end
    end else begin : g_nochk
        assign mismatch = 1'b0;
    end
endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: randomized and directed checks of decoder_3to8 against an arithmetic reference model
module tb_decoder_3to8;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] in = 3'd0;
    logic [7:0] d, d_q;
    logic       d_q_valid, mismatch;
    int         tests = 0;
    int         fails = 0;

    decoder_3to8 dut (
        .clk(clk), .reset(reset), .en(en), .in(in),
        .d(d), .d_q(d_q), .d_q_valid(d_q_valid), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic e, input logic [2:0] s);
        return e ? 8'(2 ** s) : 8'h00;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        en = 1'b1;
        in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (d !== 8'h04) begin fails++; $display("FAIL reset_d got %h want 04", d); end
            tests++;
            if (d_q !== 8'h00 || d_q_valid !== 1'b0 || mismatch !== 1'b0) begin
                fails++;
                $display("FAIL reset_state got d_q=%h v=%b m=%b want 00 0 0", d_q, d_q_valid, mismatch);
            end
        end
    endtask

    task automatic test_en_off;
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in = 3'(i);
            #1;
            tests++;
            if (d !== 8'h00) begin fails++; $display("FAIL en_off_d in=%0d got %h want 00", i, d); end
            @(posedge clk); #1;
            tests++;
            if (d_q !== 8'h00 || d_q_valid !== 1'b1) begin
                fails++;
                $display("FAIL en_off_q in=%0d got d_q=%h v=%b want 00 1", i, d_q, d_q_valid);
            end
        end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = 3'(i);
            #1;
            tests++;
            if (d !== model(1'b1, 3'(i))) begin
                fails++;
                $display("FAIL sweep_d in=%0d got %h want %h", i, d, model(1'b1, 3'(i)));
            end
            @(posedge clk); #1;
            tests++;
            if (d_q !== model(1'b1, 3'(i)) || mismatch !== 1'b0) begin
                fails++;
                $display("FAIL sweep_q in=%0d got d_q=%h m=%b want %h 0", i, d_q, mismatch, model(1'b1, 3'(i)));
            end
        end
    endtask

    task automatic test_en_toggle;
        @(negedge clk);
        en = 1'b1;
        in = 3'b111;
        #1;
        tests++;
        if (d !== 8'h80) begin fails++; $display("FAIL toggle_on got %h want 80", d); end
        en = 1'b0;
        #1;
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL toggle_off got %h want 00", d); end
        @(posedge clk); #1;
        tests++;
        if (d_q !== 8'h00) begin fails++; $display("FAIL toggle_q got %h want 00", d_q); end
    endtask

    task automatic test_random;
        logic [7:0] exp_d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            en = 1'($urandom_range(0, 3) != 0);
            in = 3'($urandom);
            exp_d = model(en, in);
            #1;
            tests++;
            if (d !== exp_d || (d & (d - 8'd1)) != 8'h00) begin
                fails++;
                $display("FAIL rand_d en=%b in=%0d got %h want %h", en, in, d, exp_d);
            end
            @(posedge clk); #1;
            tests++;
            if (d_q !== exp_d || mismatch !== 1'b0) begin
                fails++;
                $display("FAIL rand_q en=%b in=%0d got d_q=%h m=%b want %h 0", en, in, d_q, mismatch, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        en = 1'b1;
        in = 3'd4;
        @(posedge clk); #1;
        tests++;
        if (d_q !== 8'h10) begin fails++; $display("FAIL mid_pre got %h want 10", d_q); end
        #1 reset = 1'b0;
        #1;
        tests++;
        if (d_q !== 8'h00 || d_q_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got d_q=%h v=%b want 00 0", d_q, d_q_valid);
        end
        tests++;
        if (d !== 8'h10) begin fails++; $display("FAIL mid_d got %h want 10", d); end
        @(negedge clk);
        reset = 1'b1;
        in = 3'd6;
        @(posedge clk); #1;
        tests++;
        if (d_q !== 8'h40 || d_q_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_release got d_q=%h v=%b want 40 1", d_q, d_q_valid);
        end
    endtask

    task automatic test_mismatch;
        @(negedge clk);
        en = 1'b1;
        in = 3'b001;
        force dut.g = 8'h03;
        @(posedge clk); #1;
        tests++;
        if (mismatch !== 1'b1) begin fails++; $display("FAIL mm_set got %b want 1", mismatch); end
        release dut.g;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in = 3'($urandom);
            @(posedge clk); #1;
            tests++;
            if (mismatch !== 1'b1) begin fails++; $display("FAIL mm_sticky got %b want 1", mismatch); end
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if (mismatch !== 1'b0) begin fails++; $display("FAIL mm_clear got %b want 0", mismatch); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (mismatch !== 1'b0) begin fails++; $display("FAIL mm_after got %b want 0", mismatch); end
    endtask

    initial begin
        test_reset;
        test_en_off;
        test_sweep;
        test_en_toggle;
        test_random;
        test_reset_mid;
        test_mismatch;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
